id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus the EX operand front end; drives the ALU inputs directly.

---
 rtl/id_ex_stage_pkg.sv | 51 +++++
 rtl/id_ex_stage_fwd_mux.sv | 45 ++++
 rtl/id_ex_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_pkg
// Purpose  : Shared CPU definitions for the ID/EX stage and the ALU. Holds
//            the ALU control codes, the ALUOp codes from the main decoder,
//            the funct7/funct3 constants, and the registered control bundle.
// Revision : 1.0  initial release
// ============================================================================
package id_ex_stage_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RADDR_DEF = 5;

  // ALU operation select, shared with the ALU
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_MUL = 3'b111
  } alu_ctrl_e;

  // ALUOp from the main decoder
  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_IARITH = 2'b11
  } aluop_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // Control bits carried through ID/EX; all-zero is a bubble
  typedef struct packed {
    logic   valid;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   alusrc;
    aluop_e aluop;
  } idex_ctrl_t;

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : fwd_mux
// Purpose  : Operand forwarding select for one source register. EX/MEM has
//            priority over MEM/WB; register x0 is never forwarded.
// Ports    : rs_i            source register address
//            rf_data_i       registered register-file read data
//            exmem_*_i       EX/MEM writeback source (regwrite, rd, data)
//            memwb_*_i       MEM/WB writeback source (regwrite, rd, data)
//            data_o          forwarded operand
// Revision : 1.0  initial release
// ============================================================================
module fwd_mux #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] rs_i,
  input  logic [XLEN-1:0]  rf_data_i,
  input  logic             exmem_regwrite_i,
  input  logic [RADDR-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]  exmem_data_i,
  input  logic             memwb_regwrite_i,
  input  logic [RADDR-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]  memwb_data_i,
  output logic [XLEN-1:0]  data_o
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
  assign memwb_hit = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);

  // EX/MEM holds the younger result, so it must win when both match
  always_comb begin
    data_o = rf_data_i;
    if (exmem_hit) begin
      data_o = exmem_data_i;
    end else if (memwb_hit) begin
      data_o = memwb_data_i;
    end
  end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register plus the EX operand front end. Captures
//            decoded ID fields, decodes {ALUOp,funct} into the ALU control,
//            forwards from EX/MEM and MEM/WB, applies the ALUSrc immediate
//            mux and flags load-use hazards against the ID instruction.
// Config   : IDEX_FORWARD_EN - when defined, operands are forwarded from
//            EX/MEM / MEM/WB; otherwise the registered read data is used and
//            the exmem_* / memwb_* inputs are ignored.
// Ports    : clk_i, rst_i (async, active-low), stall_i, flush_i
//            id_*_i      decoded instruction fields and control bits
//            exmem_*_i   EX/MEM writeback source
//            memwb_*_i   MEM/WB writeback source
//            alu_*_o     ALU operands and operation
//            ex_*_o      registered destination / control, store data
//            load_use_o  load-use hazard against the current ID instruction
// Revision : 1.0  initial release
// ============================================================================
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [RADDR-1:0] id_rs1_i,
  input  logic [RADDR-1:0] id_rs2_i,
  input  logic [RADDR-1:0] id_rd_i,
  input  logic [9:0]       id_funct_i,
  input  logic [1:0]       id_aluop_i,
  input  logic             id_alusrc_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_memwrite_i,
  input  logic             id_memtoreg_i,
  input  logic             exmem_regwrite_i,
  input  logic [RADDR-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]  exmem_data_i,
  input  logic             memwb_regwrite_i,
  input  logic [RADDR-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]  memwb_data_i,
  output logic [XLEN-1:0]  alu_data1_o,
  output logic [XLEN-1:0]  alu_data2_o,
  output logic [2:0]       alu_ctrl_o,
  output logic [XLEN-1:0]  ex_store_data_o,
  output logic [RADDR-1:0] ex_rd_o,
  output logic             ex_valid_o,
  output logic             ex_regwrite_o,
  output logic             ex_memread_o,
  output logic             ex_memwrite_o,
  output logic             ex_memtoreg_o,
  output logic             load_use_o
);

  idex_ctrl_t       ctrl_q,     ctrl_d;
  logic [9:0]       funct_q,    funct_d;
  logic [RADDR-1:0] rs1_q,      rs1_d;
  logic [RADDR-1:0] rs2_q,      rs2_d;
  logic [RADDR-1:0] rd_q,       rd_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  imm_q,      imm_d;

  // --------------------------------------------------------------------------
  // Pipeline register: flush beats stall beats load
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl_d     = ctrl_q;
    funct_d    = funct_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    if (flush_i) begin
      ctrl_d     = '0;
      funct_d    = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
    end else if (!stall_i) begin
      ctrl_d.valid    = id_valid_i;
      ctrl_d.regwrite = id_regwrite_i;
      ctrl_d.memread  = id_memread_i;
      ctrl_d.memwrite = id_memwrite_i;
      ctrl_d.memtoreg = id_memtoreg_i;
      ctrl_d.alusrc   = id_alusrc_i;
      ctrl_d.aluop    = aluop_e'(id_aluop_i);
      funct_d         = id_funct_i;
      rs1_d           = id_rs1_i;
      rs2_d           = id_rs2_i;
      rd_d            = id_rd_i;
      rs1_data_d      = id_rs1_data_i;
      rs2_data_d      = id_rs2_data_i;
      imm_d           = id_imm_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q     <= '0;
      funct_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      funct_q    <= funct_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  // --------------------------------------------------------------------------
  // ALU decode; any unlisted encoding falls back to ADD
  // --------------------------------------------------------------------------
  logic [6:0] funct7;
  logic [2:0] funct3;
  alu_ctrl_e  alu_ctrl;

  assign funct7 = funct_q[9:3];
  assign funct3 = funct_q[2:0];

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ctrl_q.aluop)
      ALUOP_LDST:   alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        // Full-funct matches first; AND/OR only look at funct3
        if (funct7 == F7_BASE && funct3 == F3_ADD) begin
          alu_ctrl = ALU_ADD;
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          alu_ctrl = ALU_SUB;
        end else if (funct7 == F7_MULDIV && funct3 == F3_ADD) begin
          alu_ctrl = ALU_MUL;
        end else if (funct3 == F3_AND) begin
          alu_ctrl = ALU_AND;
        end else if (funct3 == F3_OR) begin
          alu_ctrl = ALU_OR;
        end
      end
      ALUOP_IARITH: begin
        if (funct3 == F3_AND) begin
          alu_ctrl = ALU_AND;
        end else if (funct3 == F3_OR) begin
          alu_ctrl = ALU_OR;
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand selection
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

`ifdef IDEX_FORWARD_EN
  fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs1 (
    .rs_i             (rs1_q),
    .rf_data_i        (rs1_data_q),
    .exmem_regwrite_i (exmem_regwrite_i),
    .exmem_rd_i       (exmem_rd_i),
    .exmem_data_i     (exmem_data_i),
    .memwb_regwrite_i (memwb_regwrite_i),
    .memwb_rd_i       (memwb_rd_i),
    .memwb_data_i     (memwb_data_i),
    .data_o           (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs2 (
    .rs_i             (rs2_q),
    .rf_data_i        (rs2_data_q),
    .exmem_regwrite_i (exmem_regwrite_i),
    .exmem_rd_i       (exmem_rd_i),
    .exmem_data_i     (exmem_data_i),
    .memwb_regwrite_i (memwb_regwrite_i),
    .memwb_rd_i       (memwb_rd_i),
    .memwb_data_i     (memwb_data_i),
    .data_o           (rs2_fwd)
  );
`else
  assign rs1_fwd = rs1_data_q;
  assign rs2_fwd = rs2_data_q;

  // Writeback sources and registered source addresses only matter when forwarding
  logic unused_fwd;
  assign unused_fwd = ^{exmem_regwrite_i, exmem_rd_i, exmem_data_i,
                        memwb_regwrite_i, memwb_rd_i, memwb_data_i, rs1_q, rs2_q};
`endif

  assign alu_data1_o     = rs1_fwd;
  assign alu_data2_o     = ctrl_q.alusrc ? imm_q : rs2_fwd;
  assign alu_ctrl_o      = alu_ctrl;
  assign ex_store_data_o = rs2_fwd;
  assign ex_rd_o         = rd_q;
  assign ex_valid_o      = ctrl_q.valid;
  assign ex_regwrite_o   = ctrl_q.regwrite;
  assign ex_memread_o    = ctrl_q.memread;
  assign ex_memwrite_o   = ctrl_q.memwrite;
  assign ex_memtoreg_o   = ctrl_q.memtoreg;

  // Load in EX whose result the ID instruction reads; purely combinational so
  // the hazard unit sees it in the same cycle regardless of stall_i
  assign load_use_o = ctrl_q.valid && ctrl_q.memread && (rd_q != '0) &&
                      ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage: decode table, directed
//            corner sequences and randomized traffic against a reference
//            model of the ID/EX stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

  localparam logic [2:0] C_AND = 3'b000;
  localparam logic [2:0] C_OR  = 3'b001;
  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_SUB = 3'b110;
  localparam logic [2:0] C_MUL = 3'b111;

  typedef struct packed {
    logic        valid;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic [1:0]  aluop;
    logic [9:0]  funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
  } inst_t;

  typedef struct packed {
    logic [1:0] op;
    logic [9:0] f;
    logic [2:0] exp;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  inst_t       cur = '0;
  inst_t       mdl = '0;
  logic        exmem_regwrite_i = 1'b0;
  logic [4:0]  exmem_rd_i = '0;
  logic [31:0] exmem_data_i = '0;
  logic        memwb_regwrite_i = 1'b0;
  logic [4:0]  memwb_rd_i = '0;
  logic [31:0] memwb_data_i = '0;

  logic [31:0] alu_data1_o, alu_data2_o, ex_store_data_o;
  logic [2:0]  alu_ctrl_o;
  logic [4:0]  ex_rd_o;
  logic        ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o;
  logic        load_use_o;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .id_valid_i       (cur.valid),
    .id_rs1_data_i    (cur.d1),
    .id_rs2_data_i    (cur.d2),
    .id_imm_i         (cur.imm),
    .id_rs1_i         (cur.rs1),
    .id_rs2_i         (cur.rs2),
    .id_rd_i          (cur.rd),
    .id_funct_i       (cur.funct),
    .id_aluop_i       (cur.aluop),
    .id_alusrc_i      (cur.alusrc),
    .id_regwrite_i    (cur.regwrite),
    .id_memread_i     (cur.memread),
    .id_memwrite_i    (cur.memwrite),
    .id_memtoreg_i    (cur.memtoreg),
    .exmem_regwrite_i (exmem_regwrite_i),
    .exmem_rd_i       (exmem_rd_i),
    .exmem_data_i     (exmem_data_i),
    .memwb_regwrite_i (memwb_regwrite_i),
    .memwb_rd_i       (memwb_rd_i),
    .memwb_data_i     (memwb_data_i),
    .alu_data1_o      (alu_data1_o),
    .alu_data2_o      (alu_data2_o),
    .alu_ctrl_o       (alu_ctrl_o),
    .ex_store_data_o  (ex_store_data_o),
    .ex_rd_o          (ex_rd_o),
    .ex_valid_o       (ex_valid_o),
    .ex_regwrite_o    (ex_regwrite_o),
    .ex_memread_o     (ex_memread_o),
    .ex_memwrite_o    (ex_memwrite_o),
    .ex_memtoreg_o    (ex_memtoreg_o),
    .load_use_o       (load_use_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: mnemonic-level decode of {ALUOp, funct7, funct3}
  function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [9:0] f);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = f[9:3];
    f3 = f[2:0];
    if (op == 2'b00) return C_ADD;
    if (op == 2'b01) return C_SUB;
    if (op == 2'b10) begin
      if (f3 == 3'b000 && f7 == 7'b0000000) return C_ADD;
      if (f3 == 3'b000 && f7 == 7'b0100000) return C_SUB;
      if (f3 == 3'b000 && f7 == 7'b0000001) return C_MUL;
    end
    if (f3 == 3'b111) return C_AND;
    if (f3 == 3'b110) return C_OR;
    return C_ADD;
  endfunction

  // Reference: value of register rs as seen by EX this cycle
  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
`ifdef IDEX_FORWARD_EN
    if (rs != 0 && exmem_regwrite_i && exmem_rd_i == rs) return exmem_data_i;
    if (rs != 0 && memwb_regwrite_i && memwb_rd_i == rs) return memwb_data_i;
`endif
    return rf;
  endfunction

  // One rising edge; the model takes the inputs that were present at the edge
  task automatic tick();
    @(posedge clk_i);
    if (!rst_i)       mdl = '0;
    else if (flush_i) mdl = '0;
    else if (!stall_i) mdl = cur;
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] f1, f2;
    logic        lu;
    f1 = ref_fwd(mdl.rs1, mdl.d1);
    f2 = ref_fwd(mdl.rs2, mdl.d2);
    lu = mdl.valid && mdl.memread && mdl.rd != 0 && (mdl.rd == cur.rs1 || mdl.rd == cur.rs2);
    chk({tag, ".d1"},    alu_data1_o, f1);
    chk({tag, ".d2"},    alu_data2_o, mdl.alusrc ? mdl.imm : f2);
    chk({tag, ".st"},    ex_store_data_o, f2);
    chk({tag, ".ctrl"},  {29'd0, alu_ctrl_o}, {29'd0, ref_ctrl(mdl.aluop, mdl.funct)});
    chk({tag, ".rd"},    {27'd0, ex_rd_o}, {27'd0, mdl.rd});
    chk({tag, ".flags"}, {27'd0, ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o},
        {27'd0, mdl.valid, mdl.regwrite, mdl.memread, mdl.memwrite, mdl.memtoreg});
    chk({tag, ".lu"},    {31'd0, load_use_o}, {31'd0, lu});
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{2'b00, 10'b0100000_111, C_ADD};
    vecs[1]  = '{2'b01, 10'b0000000_110, C_SUB};
    vecs[2]  = '{2'b10, 10'b0000000_000, C_ADD};
    vecs[3]  = '{2'b10, 10'b0100000_000, C_SUB};
    vecs[4]  = '{2'b10, 10'b0000001_000, C_MUL};
    vecs[5]  = '{2'b10, 10'b0000000_111, C_AND};
    vecs[6]  = '{2'b10, 10'b0000000_110, C_OR};
    vecs[7]  = '{2'b10, 10'b0000000_001, C_ADD};
    vecs[8]  = '{2'b10, 10'b0000001_111, C_AND};
    vecs[9]  = '{2'b11, 10'b0100000_000, C_ADD};
    vecs[10] = '{2'b11, 10'b0000000_111, C_AND};
    vecs[11] = '{2'b11, 10'b0000000_110, C_OR};
    vecs[12] = '{2'b11, 10'b0000000_100, C_ADD};
    vecs[13] = '{2'b10, 10'b0110000_000, C_ADD};

    // ---------------- reset state ----------------
    #12;
    chk("rst.valid", {31'd0, ex_valid_o}, 32'd0);
    chk("rst.ctrl",  {29'd0, alu_ctrl_o}, {29'd0, C_ADD});
    chk("rst.d1",    alu_data1_o, 32'd0);
    chk("rst.lu",    {31'd0, load_use_o}, 32'd0);
    rst_i = 1'b1;

    // ---------------- decode table ----------------
    foreach (vecs[i]) begin
      cur = '0;
      cur.valid = 1'b1;
      cur.aluop = vecs[i].op;
      cur.funct = vecs[i].f;
      cur.rd    = 5'd1;
      tick();
      chk($sformatf("dec%0d", i), {29'd0, alu_ctrl_o}, {29'd0, vecs[i].exp});
      check_all($sformatf("dec%0d", i));
    end

    // ---------------- R-type SUB with register data ----------------
    cur = '0;
    cur.valid = 1'b1; cur.regwrite = 1'b1; cur.aluop = 2'b10;
    cur.funct = 10'b0100000_000; cur.rs1 = 5'd5; cur.rs2 = 5'd6;
    cur.d1 = 32'd10; cur.d2 = 32'd3; cur.rd = 5'd4;
    tick();
    chk("sub.ctrl", {29'd0, alu_ctrl_o}, {29'd0, C_SUB});
    chk("sub.d1", alu_data1_o, 32'd10);
    chk("sub.d2", alu_data2_o, 32'd3);

    // ---------------- forwarding priority ----------------
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd5; exmem_data_i = 32'h11;
    memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd5; memwb_data_i = 32'h22;
    #1;
`ifdef IDEX_FORWARD_EN
    chk("fwd.both", alu_data1_o, 32'h11);
`else
    chk("fwd.both", alu_data1_o, 32'd10);
`endif
    exmem_rd_i = 5'd0;
    #1;
`ifdef IDEX_FORWARD_EN
    chk("fwd.memwb", alu_data1_o, 32'h22);
`else
    chk("fwd.memwb", alu_data1_o, 32'd10);
`endif
    check_all("fwd");
    exmem_regwrite_i = 1'b0; memwb_regwrite_i = 1'b0;

    // ---------------- load-use then flush ----------------
    cur = '0;
    cur.valid = 1'b1; cur.regwrite = 1'b1; cur.memread = 1'b1; cur.memtoreg = 1'b1;
    cur.alusrc = 1'b1; cur.rd = 5'd7; cur.rs1 = 5'd2; cur.imm = 32'd16;
    tick();
    cur = '0;
    cur.valid = 1'b1; cur.rs1 = 5'd1; cur.rs2 = 5'd7; cur.aluop = 2'b10;
    #1;
    chk("lu.hit", {31'd0, load_use_o}, 32'd1);
    check_all("lu");
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("lu.flush.valid", {31'd0, ex_valid_o}, 32'd0);
    chk("lu.flush.rw",    {31'd0, ex_regwrite_o}, 32'd0);
    chk("lu.flush.lu",    {31'd0, load_use_o}, 32'd0);

    // ---------------- stall holds, stall+flush bubbles ----------------
    cur = '0;
    cur.valid = 1'b1; cur.regwrite = 1'b1; cur.aluop = 2'b11;
    cur.funct = 10'b0000000_110; cur.rd = 5'd9; cur.d1 = 32'h5a;
    tick();
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cur = inst_t'({$urandom, $urandom, $urandom, $urandom});
      tick();
      chk($sformatf("stall%0d.ctrl", k), {29'd0, alu_ctrl_o}, {29'd0, C_OR});
      chk($sformatf("stall%0d.rd", k), {27'd0, ex_rd_o}, 32'd9);
      chk($sformatf("stall%0d.d1", k), alu_data1_o, 32'h5a);
    end
    flush_i = 1'b1;
    tick();
    stall_i = 1'b0; flush_i = 1'b0;
    chk("stflush.valid", {31'd0, ex_valid_o}, 32'd0);
    chk("stflush.rd",    {27'd0, ex_rd_o}, 32'd0);
    chk("stflush.ctrl",  {29'd0, alu_ctrl_o}, {29'd0, C_ADD});

    // ---------------- addi with forwarded rs1 ----------------
    cur = '0;
    cur.valid = 1'b1; cur.regwrite = 1'b1; cur.alusrc = 1'b1; cur.aluop = 2'b11;
    cur.rs1 = 5'd3; cur.d1 = 32'h55; cur.imm = 32'hFFFF_FFFC; cur.rd = 5'd8;
    exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd3; exmem_data_i = 32'd8;
    tick();
    chk("addi.d2",   alu_data2_o, 32'hFFFF_FFFC);
`ifdef IDEX_FORWARD_EN
    chk("addi.d1",   alu_data1_o, 32'd8);
`else
    chk("addi.d1",   alu_data1_o, 32'h55);
`endif
    chk("addi.ctrl", {29'd0, alu_ctrl_o}, {29'd0, C_ADD});
    exmem_regwrite_i = 1'b0;

    // ---------------- asynchronous reset mid-run ----------------
    cur = '0;
    cur.valid = 1'b1; cur.regwrite = 1'b1; cur.rs1 = 5'd4; cur.d1 = 32'h77; cur.rd = 5'd6;
    tick();
    rst_i = 1'b0;
    mdl = '0;
    #1;
    chk("arst.valid", {31'd0, ex_valid_o}, 32'd0);
    chk("arst.ctrl",  {29'd0, alu_ctrl_o}, {29'd0, C_ADD});
    chk("arst.d1",    alu_data1_o, 32'd0);
    chk("arst.rd",    {27'd0, ex_rd_o}, 32'd0);
    #2 rst_i = 1'b1;

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 400; n++) begin
      tick();
      cur.valid    = 1'($urandom);
      cur.alusrc   = 1'($urandom);
      cur.regwrite = 1'($urandom);
      cur.memread  = 1'($urandom);
      cur.memwrite = 1'($urandom);
      cur.memtoreg = 1'($urandom);
      cur.aluop    = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       cur.funct[9:3] = 7'b0000000;
        1:       cur.funct[9:3] = 7'b0100000;
        2:       cur.funct[9:3] = 7'b0000001;
        default: cur.funct[9:3] = 7'($urandom);
      endcase
      cur.funct[2:0] = 3'($urandom);
      cur.rs1 = 5'($urandom_range(0, 7));
      cur.rs2 = 5'($urandom_range(0, 7));
      cur.rd  = 5'($urandom_range(0, 7));
      cur.d1  = $urandom;
      cur.d2  = $urandom;
      cur.imm = $urandom;
      exmem_regwrite_i = 1'($urandom);
      exmem_rd_i       = 5'($urandom_range(0, 7));
      exmem_data_i     = $urandom;
      memwb_regwrite_i = 1'($urandom);
      memwb_rd_i       = 5'($urandom_range(0, 7));
      memwb_data_i     = $urandom;
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      #1;
      check_all($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_id_ex_stage
`default_nettype wire
